// File: rtl/dbus_stream_bridge.sv
// Buffered bidirectional byte-stream bridge, UART side (A) <-> DBUS side (B).
// Define BRIDGE_STATS_EN for delivery counters and the sticky A->B stall flag.

module dbus_stream_bridge_sync #(
  parameter int c_STAGES = 1
) (
  input  logic i_clock,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);
  logic [c_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = i_d;
    for (int i = 1; i < c_STAGES; i++)
      sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) sync_q <= '0;
    else           sync_q <= sync_d;
  end

  assign o_q = sync_q[c_STAGES-1];
endmodule

module dbus_stream_bridge_fifo #(
  parameter int c_WIDTH = 8,
  parameter int c_POW2  = 2
) (
  input  logic               i_clock,
  input  logic               i_resetn,
  input  logic               i_push,
  input  logic [c_WIDTH-1:0] i_data,
  input  logic               i_pop,
  output logic [c_WIDTH-1:0] o_head,
  output logic [c_POW2:0]    o_level,
  output logic               o_full,
  output logic               o_empty
);
  localparam logic [c_POW2:0] FULLV = {1'b1, {c_POW2{1'b0}}};

  logic [c_WIDTH-1:0] mem_q [1<<c_POW2];
  logic [c_POW2-1:0]  wptr_q, wptr_d;
  logic [c_POW2-1:0]  rptr_q, rptr_d;
  logic [c_POW2:0]    cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (i_push) wptr_d = wptr_q + 1'b1;
    if (i_pop)  rptr_d = rptr_q + 1'b1;
    case ({i_push, i_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge i_clock) begin
    if (i_push) mem_q[wptr_q] <= i_data;
  end

  assign o_head  = mem_q[rptr_q];
  assign o_level = cnt_q;
  assign o_full  = (cnt_q == FULLV);
  assign o_empty = (cnt_q == '0);
endmodule

module dbus_stream_bridge_src (
  input  logic i_clock,
  input  logic i_resetn,
  input  logic i_avail,
  input  logic i_full,
  output logic o_read,
  output logic o_push
);
  typedef enum logic {S_IDLE, S_READ} state_e;
  state_e state_q, state_d;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_avail && !i_full) state_d = S_READ;
      S_READ: if (!i_avail)           state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_read = (state_q == S_READ);
    o_push = (state_q == S_IDLE) && i_avail && !i_full;
  end
endmodule

module dbus_stream_bridge_snk #(
  parameter int c_WIDTH = 8
) (
  input  logic               i_clock,
  input  logic               i_resetn,
  input  logic               i_busy,
  input  logic               i_empty,
  input  logic [c_WIDTH-1:0] i_head,
  output logic               o_enable,
  output logic [c_WIDTH-1:0] o_data,
  output logic               o_pop
);
  typedef enum logic [1:0] {K_IDLE, K_OFFER, K_RELEASE} state_e;
  state_e             state_q, state_d;
  logic [c_WIDTH-1:0] data_q, data_d;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= K_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      K_IDLE:    if (!i_empty && !i_busy) state_d = K_OFFER;
      K_OFFER:   if (i_busy)              state_d = K_RELEASE;
      K_RELEASE: if (!i_busy)             state_d = K_IDLE;
      default:                            state_d = K_IDLE;
    endcase
  end

  // The head is popped once the consumer has taken it (busy seen high).
  always_comb begin
    o_enable = (state_q == K_OFFER);
    o_pop    = (state_q == K_OFFER) && i_busy;
    data_d   = data_q;
    if ((state_q == K_IDLE) && !i_empty && !i_busy) data_d = i_head;
    o_data   = data_q;
  end
endmodule

module dbus_stream_bridge #(
  parameter int c_WIDTH      = 8,
  parameter int c_A2BPOW2    = 2,
  parameter int c_B2APOW2    = 2,
  parameter int c_HIWATER    = 3,
  parameter int c_LOWATER    = 1,
  parameter int c_SYNCSTAGES = 1,
  parameter int c_CNTWIDTH   = 16
) (
  input  logic                 i_clock,
  input  logic                 i_resetn,
  input  logic                 i_asrc_avail,
  input  logic [c_WIDTH-1:0]   i_asrc_data,
  output logic                 o_asrc_read,
  output logic [c_WIDTH-1:0]   o_bsnk_data,
  output logic                 o_bsnk_enable,
  input  logic                 i_bsnk_busy,
  input  logic                 i_bsrc_avail,
  input  logic [c_WIDTH-1:0]   i_bsrc_data,
  output logic                 o_bsrc_read,
  output logic [c_WIDTH-1:0]   o_asnk_data,
  output logic                 o_asnk_enable,
  input  logic                 i_asnk_busy,
  output logic [c_A2BPOW2:0]   o_a2b_level,
  output logic [c_B2APOW2:0]   o_b2a_level,
  output logic                 o_a2b_full,
  output logic                 o_b2a_full,
  output logic                 o_stop
`ifdef BRIDGE_STATS_EN
  ,
  output logic [c_CNTWIDTH-1:0] o_a2b_count,
  output logic [c_CNTWIDTH-1:0] o_b2a_count,
  output logic                  o_a2b_stall
`endif
);
  localparam logic [c_A2BPOW2:0] HI = (c_A2BPOW2+1)'(c_HIWATER);
  localparam logic [c_A2BPOW2:0] LO = (c_A2BPOW2+1)'(c_LOWATER);

  if (c_SYNCSTAGES < 1 || c_LOWATER >= c_HIWATER || c_CNTWIDTH < 1) begin : g_bad
    $error("dbus_stream_bridge: illegal parameter set");
  end

  logic a_avail_s, b_avail_s, b_busy_s, a_busy_s;
  logic a2b_push, a2b_pop, a2b_empty;
  logic b2a_push, b2a_pop, b2a_empty;
  logic [c_WIDTH-1:0] a2b_head, b2a_head;
  logic stop_q, stop_d;

  dbus_stream_bridge_sync #(.c_STAGES(c_SYNCSTAGES)) u_sy_aa (
    .i_clock, .i_resetn, .i_d(i_asrc_avail), .o_q(a_avail_s));
  dbus_stream_bridge_sync #(.c_STAGES(c_SYNCSTAGES)) u_sy_ba (
    .i_clock, .i_resetn, .i_d(i_bsrc_avail), .o_q(b_avail_s));
  dbus_stream_bridge_sync #(.c_STAGES(c_SYNCSTAGES)) u_sy_bb (
    .i_clock, .i_resetn, .i_d(i_bsnk_busy), .o_q(b_busy_s));
  dbus_stream_bridge_sync #(.c_STAGES(c_SYNCSTAGES)) u_sy_ab (
    .i_clock, .i_resetn, .i_d(i_asnk_busy), .o_q(a_busy_s));

  dbus_stream_bridge_src u_a_src (
    .i_clock, .i_resetn, .i_avail(a_avail_s), .i_full(o_a2b_full),
    .o_read(o_asrc_read), .o_push(a2b_push));

  dbus_stream_bridge_fifo #(.c_WIDTH(c_WIDTH), .c_POW2(c_A2BPOW2)) u_a2b (
    .i_clock, .i_resetn, .i_push(a2b_push), .i_data(i_asrc_data),
    .i_pop(a2b_pop), .o_head(a2b_head), .o_level(o_a2b_level),
    .o_full(o_a2b_full), .o_empty(a2b_empty));

  dbus_stream_bridge_snk #(.c_WIDTH(c_WIDTH)) u_b_snk (
    .i_clock, .i_resetn, .i_busy(b_busy_s), .i_empty(a2b_empty),
    .i_head(a2b_head), .o_enable(o_bsnk_enable), .o_data(o_bsnk_data),
    .o_pop(a2b_pop));

  dbus_stream_bridge_src u_b_src (
    .i_clock, .i_resetn, .i_avail(b_avail_s), .i_full(o_b2a_full),
    .o_read(o_bsrc_read), .o_push(b2a_push));

  dbus_stream_bridge_fifo #(.c_WIDTH(c_WIDTH), .c_POW2(c_B2APOW2)) u_b2a (
    .i_clock, .i_resetn, .i_push(b2a_push), .i_data(i_bsrc_data),
    .i_pop(b2a_pop), .o_head(b2a_head), .o_level(o_b2a_level),
    .o_full(o_b2a_full), .o_empty(b2a_empty));

  dbus_stream_bridge_snk #(.c_WIDTH(c_WIDTH)) u_a_snk (
    .i_clock, .i_resetn, .i_busy(a_busy_s), .i_empty(b2a_empty),
    .i_head(b2a_head), .o_enable(o_asnk_enable), .o_data(o_asnk_data),
    .o_pop(b2a_pop));

  // Hysteresis between the watermarks keeps CTS from chattering.
  always_comb begin
    stop_d = stop_q;
    if (o_a2b_level >= HI)      stop_d = 1'b1;
    else if (o_a2b_level <= LO) stop_d = 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) stop_q <= 1'b0;
    else           stop_q <= stop_d;
  end

  assign o_stop = stop_q;

`ifdef BRIDGE_STATS_EN
  logic [c_CNTWIDTH-1:0] a2b_cnt_q, a2b_cnt_d;
  logic [c_CNTWIDTH-1:0] b2a_cnt_q, b2a_cnt_d;
  logic                  stall_q, stall_d;

  // Source idle with avail pending means it is waiting on a full FIFO.
  always_comb begin
    a2b_cnt_d = a2b_pop ? a2b_cnt_q + 1'b1 : a2b_cnt_q;
    b2a_cnt_d = b2a_pop ? b2a_cnt_q + 1'b1 : b2a_cnt_q;
    stall_d   = stall_q | (a_avail_s & ~o_asrc_read & o_a2b_full);
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      a2b_cnt_q <= '0;
      b2a_cnt_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      a2b_cnt_q <= a2b_cnt_d;
      b2a_cnt_q <= b2a_cnt_d;
      stall_q   <= stall_d;
    end
  end

  assign o_a2b_count = a2b_cnt_q;
  assign o_b2a_count = b2a_cnt_q;
  assign o_a2b_stall = stall_q;
`endif
endmodule

// File: tb/tb_dbus_stream_bridge.sv
// Directed self-checking bench for dbus_stream_bridge (default parameters).
// Samples 1 time unit after each rising edge.

module tb_dbus_stream_bridge;
  logic       i_clock;
  logic       i_resetn;
  logic       i_asrc_avail;
  logic [7:0] i_asrc_data;
  logic       o_asrc_read;
  logic [7:0] o_bsnk_data;
  logic       o_bsnk_enable;
  logic       i_bsnk_busy;
  logic       i_bsrc_avail;
  logic [7:0] i_bsrc_data;
  logic       o_bsrc_read;
  logic [7:0] o_asnk_data;
  logic       o_asnk_enable;
  logic       i_asnk_busy;
  logic [2:0] o_a2b_level;
  logic [2:0] o_b2a_level;
  logic       o_a2b_full;
  logic       o_b2a_full;
  logic       o_stop;
`ifdef BRIDGE_STATS_EN
  logic [15:0] o_a2b_count;
  logic [15:0] o_b2a_count;
  logic        o_a2b_stall;
`endif

  int checks = 0;
  int errors = 0;

  dbus_stream_bridge dut (
    .i_clock(i_clock), .i_resetn(i_resetn),
    .i_asrc_avail(i_asrc_avail), .i_asrc_data(i_asrc_data),
    .o_asrc_read(o_asrc_read),
    .o_bsnk_data(o_bsnk_data), .o_bsnk_enable(o_bsnk_enable),
    .i_bsnk_busy(i_bsnk_busy),
    .i_bsrc_avail(i_bsrc_avail), .i_bsrc_data(i_bsrc_data),
    .o_bsrc_read(o_bsrc_read),
    .o_asnk_data(o_asnk_data), .o_asnk_enable(o_asnk_enable),
    .i_asnk_busy(i_asnk_busy),
    .o_a2b_level(o_a2b_level), .o_b2a_level(o_b2a_level),
    .o_a2b_full(o_a2b_full), .o_b2a_full(o_b2a_full),
    .o_stop(o_stop)
`ifdef BRIDGE_STATS_EN
    , .o_a2b_count(o_a2b_count), .o_b2a_count(o_b2a_count),
    .o_a2b_stall(o_a2b_stall)
`endif
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic wait_a_read(input logic lvl, input string tag);
    int n = 0;
    while (o_asrc_read !== lvl && n < 200) begin tick(1); n++; end
    if (o_asrc_read !== lvl) check(tag, 32'(o_asrc_read), 32'(lvl));
  endtask

  task automatic wait_b_read(input logic lvl, input string tag);
    int n = 0;
    while (o_bsrc_read !== lvl && n < 200) begin tick(1); n++; end
    if (o_bsrc_read !== lvl) check(tag, 32'(o_bsrc_read), 32'(lvl));
  endtask

  task automatic wait_b_en(input logic lvl, input string tag);
    int n = 0;
    while (o_bsnk_enable !== lvl && n < 200) begin tick(1); n++; end
    if (o_bsnk_enable !== lvl) check(tag, 32'(o_bsnk_enable), 32'(lvl));
  endtask

  task automatic wait_a_en(input logic lvl, input string tag);
    int n = 0;
    while (o_asnk_enable !== lvl && n < 200) begin tick(1); n++; end
    if (o_asnk_enable !== lvl) check(tag, 32'(o_asnk_enable), 32'(lvl));
  endtask

  task automatic a_send(input logic [7:0] d);
    i_asrc_data  = d;
    i_asrc_avail = 1'b1;
    wait_a_read(1'b1, "a_read_up");
    i_asrc_avail = 1'b0;
    wait_a_read(1'b0, "a_read_dn");
  endtask

  task automatic b_send(input logic [7:0] d);
    i_bsrc_data  = d;
    i_bsrc_avail = 1'b1;
    wait_b_read(1'b1, "b_read_up");
    i_bsrc_avail = 1'b0;
    wait_b_read(1'b0, "b_read_dn");
  endtask

  // Leaves busy high so the sink parks in RELEASE until the next call.
  task automatic b_recv(output logic [7:0] d, input int hold);
    i_bsnk_busy = 1'b0;
    wait_b_en(1'b1, "b_en_up");
    d = o_bsnk_data;
    tick(hold);
    i_bsnk_busy = 1'b1;
    wait_b_en(1'b0, "b_en_dn");
  endtask

  task automatic a_recv(output logic [7:0] d, input int hold);
    i_asnk_busy = 1'b0;
    wait_a_en(1'b1, "a_en_up");
    d = o_asnk_data;
    tick(hold);
    i_asnk_busy = 1'b1;
    wait_a_en(1'b0, "a_en_dn");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int offers;
    i_resetn     = 1'b0;
    i_asrc_avail = 1'b0;
    i_asrc_data  = 8'h00;
    i_bsnk_busy  = 1'b0;
    i_bsrc_avail = 1'b0;
    i_bsrc_data  = 8'h00;
    i_asnk_busy  = 1'b0;
    tick(3);
    check("rst_a2b_level", 32'(o_a2b_level), 0);
    check("rst_bsnk_en", 32'(o_bsnk_enable), 0);
    check("rst_stop", 32'(o_stop), 0);
    @(negedge i_clock);
    i_resetn = 1'b1;
    tick(2);

    // Single byte, exact latency
    i_asrc_data  = 8'h5A;
    i_asrc_avail = 1'b1;
    tick(1);
    check("t1_read_e1", 32'(o_asrc_read), 0);
    tick(1);
    check("t1_read_e2", 32'(o_asrc_read), 1);
    check("t1_level_e2", 32'(o_a2b_level), 1);
    check("t1_en_e2", 32'(o_bsnk_enable), 0);
    tick(1);
    check("t1_en_e3", 32'(o_bsnk_enable), 1);
    check("t1_data_e3", 32'(o_bsnk_data), 32'h5A);
    i_asrc_avail = 1'b0;
    i_bsnk_busy  = 1'b1;
    tick(1);
    check("t1_en_e4", 32'(o_bsnk_enable), 1);
    check("t1_read_e4", 32'(o_asrc_read), 1);
    tick(1);
    check("t1_en_e5", 32'(o_bsnk_enable), 0);
    check("t1_read_e5", 32'(o_asrc_read), 0);
    check("t1_level_e5", 32'(o_a2b_level), 0);
    check("t1_data_hold", 32'(o_bsnk_data), 32'h5A);

    // Overflow: busy held, 5 bytes into depth 4
    for (int i = 1; i <= 4; i++) a_send(8'(i));
    tick(2);
    check("t2_full", 32'(o_a2b_full), 1);
    check("t2_level", 32'(o_a2b_level), 4);
    check("t2_stop", 32'(o_stop), 1);
    i_asrc_data  = 8'h05;
    i_asrc_avail = 1'b1;
    tick(8);
    check("t2_no_read", 32'(o_asrc_read), 0);
    check("t2_level_held", 32'(o_a2b_level), 4);
`ifdef BRIDGE_STATS_EN
    check("t2_stall", 32'(o_a2b_stall), 1);
`endif
    fork
      begin
        wait_a_read(1'b1, "t2_5th_up");
        i_asrc_avail = 1'b0;
        wait_a_read(1'b0, "t2_5th_dn");
      end
      begin
        for (int i = 1; i <= 5; i++) begin
          logic [7:0] r;
          b_recv(r, 0);
          check("t2_order", 32'(r), i);
        end
      end
    join
    tick(2);
    check("t2_empty", 32'(o_a2b_level), 0);
    check("t2_stop_clr", 32'(o_stop), 0);

    // Watermarks 3/1
    a_send(8'h31);
    a_send(8'h32);
    tick(2);
    check("t3_stop_l2up", 32'(o_stop), 0);
    a_send(8'h33);
    tick(2);
    check("t3_level3", 32'(o_a2b_level), 3);
    check("t3_stop_l3", 32'(o_stop), 1);
    b_recv(d, 0);
    check("t3_d1", 32'(d), 32'h31);
    tick(2);
    check("t3_level2", 32'(o_a2b_level), 2);
    check("t3_stop_l2dn", 32'(o_stop), 1);
    b_recv(d, 0);
    check("t3_d2", 32'(d), 32'h32);
    tick(2);
    check("t3_stop_l1", 32'(o_stop), 0);
    b_recv(d, 1);
    check("t3_d3", 32'(d), 32'h33);

    // Concurrent streams with jitter
    i_asnk_busy = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          tick(int'($urandom_range(0, 3)));
          a_send(8'(8'h40 + i));
        end
      end
      begin
        for (int i = 0; i < 16; i++) begin
          logic [7:0] r;
          tick(int'($urandom_range(0, 4)));
          b_recv(r, int'($urandom_range(0, 3)));
          check("t4_a2b_seq", 32'(r), 32'(8'(8'h40 + i)));
        end
      end
      begin
        for (int i = 0; i < 16; i++) begin
          tick(int'($urandom_range(0, 3)));
          b_send(8'(8'hC0 + i));
        end
      end
      begin
        for (int i = 0; i < 16; i++) begin
          logic [7:0] r;
          tick(int'($urandom_range(0, 4)));
          a_recv(r, int'($urandom_range(0, 3)));
          check("t4_b2a_seq", 32'(r), 32'(8'(8'hC0 + i)));
        end
      end
    join
    tick(3);
    check("t4_a2b_empty", 32'(o_a2b_level), 0);
    check("t4_b2a_empty", 32'(o_b2a_level), 0);
`ifdef BRIDGE_STATS_EN
    check("t4_a2b_count", 32'(o_a2b_count), 25);
    check("t4_b2a_count", 32'(o_b2a_count), 16);
`endif

    // Reset while an offer is live and 3 bytes are held
    a_send(8'hA1);
    a_send(8'hA2);
    a_send(8'hA3);
    i_bsnk_busy = 1'b0;
    wait_b_en(1'b1, "t5_en_up");
    check("t5_pre_level", 32'(o_a2b_level), 3);
    check("t5_pre_stop", 32'(o_stop), 1);
    #2;
    i_resetn = 1'b0;
    #1;
    check("t5_en", 32'(o_bsnk_enable), 0);
    check("t5_bdata", 32'(o_bsnk_data), 0);
    check("t5_level", 32'(o_a2b_level), 0);
    check("t5_stop", 32'(o_stop), 0);
    check("t5_misc", {26'd0, o_asrc_read, o_bsrc_read, o_asnk_enable,
                      o_a2b_full, o_b2a_full, |o_b2a_level}, 0);
    check("t5_adata", 32'(o_asnk_data), 0);
    tick(2);
    @(negedge i_clock);
    i_resetn = 1'b1;
    offers = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (o_bsnk_enable) offers++;
    end
    check("t5_no_offer", 32'(offers), 0);
    check("t5_level_after", 32'(o_a2b_level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dbus_stream_bridge.md
# dbus_stream_bridge

Parametrised bidirectional byte-stream bridge between a UART-side endpoint pair (A) and a DBUS-side endpoint pair (B). Each direction has its own power-of-two elastic FIFO. Every port uses a four-phase handshake, and a hysteresis flow-control flag is driven towards the A producer. It sits between the UART RX/TX FIFOs and the DBUS link controller, replacing the single-register bridge with a buffered, width-, depth- and sync-configurable one.

## Interface
Parameters:
- c_WIDTH, 8, data width of every port
- c_A2BPOW2, 2, log2 of the A→B FIFO depth (depth 4)
- c_B2APOW2, 2, log2 of the B→A FIFO depth
- c_HIWATER, 3, A→B level at or above which o_stop asserts
- c_LOWATER, 1, A→B level at or below which o_stop deasserts (must be < c_HIWATER)
- c_SYNCSTAGES, 1, flops on each avail/busy input (minimum 1)
- c_CNTWIDTH, 16, statistics counter width (used only with BRIDGE_STATS_EN)

Ports:
- i_clock  in  1  the single clock for all logic
- i_resetn  in  1  asynchronous, active-low reset
- i_asrc_avail / i_asrc_data  in  1 / c_WIDTH  A source (UART RX): byte available, data
- o_asrc_read  out  1  A source read acknowledge
- o_bsnk_data / o_bsnk_enable  out  c_WIDTH / 1  B sink (DBUS transmit)
- i_bsnk_busy  in  1  B sink busy
- i_bsrc_avail / i_bsrc_data  in  1 / c_WIDTH  B source (DBUS receive)
- o_bsrc_read  out  1  B source read acknowledge
- o_asnk_data / o_asnk_enable  out  c_WIDTH / 1  A sink (UART TX)
- i_asnk_busy  in  1  A sink busy
- o_a2b_level / o_b2a_level  out  c_A2BPOW2+1 / c_B2APOW2+1  FIFO occupancy
- o_a2b_full / o_b2a_full  out  1  FIFO full
- o_stop  out  1  flow control towards the A producer (drives CTS), 1 = stop

## Operation
- Source FSM (one per direction):
  - IDLE → READ when synced avail = 1 and the FIFO is not full. On that edge: read = 1, data pushed.
  - READ holds read = 1 until synced avail = 0, then goes to IDLE with read = 0.
  - Producer holds data stable while avail = 1. Data is sampled only on the push edge.
- Sink FSM (one per direction):
  - IDLE → OFFER when the FIFO is not empty and synced busy = 0. enable = 1, data = FIFO head.
  - OFFER → RELEASE when synced busy = 1. enable = 0, head popped on this edge.
  - RELEASE → IDLE when synced busy = 0.
  - Data output holds the last offered byte until the next offer.
- FIFO behaviour:
  - Full: the source stays in IDLE and no read is issued; no byte is ever dropped.
  - Empty: the sink stays in IDLE.
  - Simultaneous push and pop: level unchanged. Pointers wrap modulo depth.
  - Full is signalled at level = 2^POW2.
- o_stop: set when a2b_level ≥ c_HIWATER, cleared when a2b_level ≤ c_LOWATER, otherwise held.
- Reset (asynchronous, may arrive mid-handshake):
  - All outputs go to 0: read, enable, data, levels, full, stop.
  - FSMs go to IDLE, pointers clear, FIFO contents are discarded, synchronizers clear.
  - A byte whose handshake was in flight is lost.

## Timing
- Synced input = raw input delayed by c_SYNCSTAGES edges.
- S = c_SYNCSTAGES.
- Empty FIFO, sink idle, busy = 0: avail rising before edge 1 → read = 1 and push at edge S+1 → enable = 1 at edge S+2.
- Read falls S+1 edges after avail falls.
- Enable falls S+1 edges after busy rises, and the pop happens on that same edge.
- Level and full update on the edge after push/pop. o_stop updates one edge after the level.
- Steady throughput: each endpoint is limited by its own handshake round trip. The two directions are fully independent.

## Configuration
- BRIDGE_STATS_EN defined:
  - Adds outputs o_a2b_count and o_b2a_count (c_CNTWIDTH each).
  - Each counts bytes popped at its sink (completed deliveries). Wraps modulo 2^c_CNTWIDTH; reset to 0.
  - Adds o_a2b_stall, 1 bit: sticky flag set when A avail is pending while the A→B FIFO is full. Cleared only by reset.
- BRIDGE_STATS_EN not defined: none of these ports exist, and behaviour is otherwise identical.

## Test plan
- Reset, then A sends 0x5A with S = 1 and B busy held low → read at edge 2, o_bsnk_enable = 1 with data 0x5A at edge 3. Raise busy → enable drops and level returns to 0.
- Hold i_bsnk_busy = 1 and send 5 bytes 0x01..0x05 into depth 4 → first 4 accepted, o_a2b_full = 1, 5th avail left unacknowledged. Release busy → bytes delivered in order 0x01..0x05.
- Watermarks 3/1: fill to 3 → o_stop = 1. Drain to 2 → o_stop stays 1. Drain to 1 → o_stop = 0.
- B→A and A→B streams of 16 bytes each run concurrently with random busy/avail jitter → both sinks receive exact sequences, no loss or duplication.
- Assert i_resetn low while o_bsnk_enable = 1 and the FIFO holds 3 bytes → all outputs 0 immediately, levels 0, no further offers after release.
- With BRIDGE_STATS_EN: deliver 0x10000 bytes at c_CNTWIDTH = 16 → o_a2b_count wraps to 0. Overflow attempt sets o_a2b_stall = 1.
